// File: rtl/apb_mem_pkg.sv
// apb_mem_pkg: shared types and defaults for the APB-to-memory controller.
//   state_t        - controller FSM states (IDLE, CMD, RESP)
//   *_W_DEF        - default widths for APB address, memory address and data
//   addr_in_range  - true when no address bit at or above addr_w is set
package apb_mem_pkg;

  localparam int unsigned PADDR_W_DEF = 12;
  localparam int unsigned ADDR_W_DEF  = 8;
  localparam int unsigned DATA_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    RESP
  } state_t;

  function automatic logic addr_in_range(input logic [31:0] paddr,
                                         input int unsigned addr_w);
    return (paddr >> addr_w) == '0;
  endfunction

endpackage

// File: rtl/apb_mem_ctrl.sv
// apb_mem_ctrl: APB3 completer driving a single-port memory with a one-cycle
// registered read. Every transfer takes setup + CMD + RESP; the memory strobes
// are high only in CMD, pready is high only in RESP.
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   psel, penable, pwrite    - APB control
//   paddr, pwdata            - APB address / write data (sampled in setup)
//   prdata, pready, pslverr  - APB response
//   mem_ce, mem_wren, mem_rden, mem_addr, mem_wr_data - memory command
//   mem_rd_data              - memory read data, valid the cycle after rden
//
// Build option: define APB_MEM_ERR_EN to reject addresses with any bit set
// above ADDR_W (no memory access, pslverr in RESP). Without it the upper
// address bits are ignored and the memory aliases.
module apb_mem_ctrl
  import apb_mem_pkg::*;
#(
  parameter int unsigned PADDR_W = PADDR_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [PADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0]  pwdata,
  output logic [DATA_W-1:0]  prdata,
  output logic               pready,
  output logic               pslverr,
  output logic               mem_ce,
  output logic               mem_wren,
  output logic               mem_rden,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wr_data,
  input  logic [DATA_W-1:0]  mem_rd_data
);

  state_t              state, state_n;
  logic                ce_n, wren_n, rden_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [DATA_W-1:0]   wdata_n;
  logic                rd_q, rd_n;     // current transfer is a read
  logic                err_q, err_n;   // current transfer is out of range
  logic                in_rng;

`ifdef APB_MEM_ERR_EN
  assign in_rng  = addr_in_range(32'(paddr), ADDR_W);
  assign pslverr = (state == RESP) && err_q;
`else
  logic unused_paddr_hi;
  assign unused_paddr_hi = ^paddr[PADDR_W-1:ADDR_W];
  assign in_rng  = 1'b1;
  assign pslverr = 1'b0;
`endif

  assign pready = (state == RESP);
  assign prdata = (state == RESP && rd_q && !err_q) ? mem_rd_data : '0;

  always_comb begin
    state_n = state;
    ce_n    = 1'b0;
    wren_n  = 1'b0;
    rden_n  = 1'b0;
    addr_n  = mem_addr;
    wdata_n = mem_wr_data;
    rd_n    = rd_q;
    err_n   = err_q;
    case (state)
      IDLE: begin
        // Only a true setup phase starts a transfer; an access phase seen
        // from IDLE has no matching setup and is ignored.
        if (psel && !penable) begin
          state_n = CMD;
          addr_n  = paddr[ADDR_W-1:0];
          wdata_n = pwdata;
          rd_n    = !pwrite;
          err_n   = !in_rng;
          ce_n    = in_rng;
          wren_n  = pwrite && in_rng;
          rden_n  = !pwrite && in_rng;
        end
      end
      // Strobes fall back to 0 by default; the memory has acted at this edge,
      // so dropping psel here cannot undo a write.
      CMD:     state_n = psel ? RESP : IDLE;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mem_ce      <= 1'b0;
      mem_wren    <= 1'b0;
      mem_rden    <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      rd_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_n;
      mem_ce      <= ce_n;
      mem_wren    <= wren_n;
      mem_rden    <= rden_n;
      mem_addr    <= addr_n;
      mem_wr_data <= wdata_n;
      rd_q        <= rd_n;
      err_q       <= err_n;
    end
  end

endmodule

// File: tb/tb_apb_mem_ctrl.sv
// tb_apb_mem_ctrl: self-checking bench for apb_mem_ctrl with a 256x8
// registered-read memory attached, directed cases plus random transfers
// checked against an array reference of memory contents.
// Honours APB_MEM_ERR_EN the same way the design does.
module tb_apb_mem_ctrl;

`ifdef APB_MEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [7:0]  pwdata, prdata;
  logic        pready, pslverr;
  logic        mem_ce, mem_wren, mem_rden;
  logic [7:0]  mem_addr, mem_wr_data, mem_rd_data;

  apb_mem_ctrl #(.PADDR_W(12), .ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .mem_ce(mem_ce), .mem_wren(mem_wren), .mem_rden(mem_rden),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  // Attached memory: registered read, read has priority over write.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_rden)      mem_rd_data <= mem[mem_addr];
      else if (mem_wren) mem[mem_addr] <= mem_wr_data;
    end
  end

  // Reference contents as seen from the APB side.
  logic [7:0] ref_mem [256];

  int n_checks = 0;
  int n_errors = 0;
  int viol     = 0;
  bit prev_ce  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Protocol invariants watched every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_wren && mem_rden) viol++;
      if (mem_ce && prev_ce)    viol++;
      if (pslverr && !pready)   viol++;
    end
    prev_ce = mem_ce;
  end

  task automatic idle(input int unsigned n);
    psel    = 1'b0;
    penable = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One full APB transfer; entered and left at #1 after a rising edge.
  task automatic xfer(input bit wr, input logic [11:0] a, input logic [7:0] d);
    bit         err;
    logic [7:0] exp_rd;
    err     = ERR_EN && (a[11:8] != 4'h0);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = d;
    @(posedge clk); #1;
    chk("cmd_ce",     32'(mem_ce),   32'(!err));
    chk("cmd_wren",   32'(mem_wren), 32'(wr && !err));
    chk("cmd_rden",   32'(mem_rden), 32'(!wr && !err));
    chk("cmd_pready", 32'(pready),   32'd0);
    if (!err)       chk("cmd_addr",  32'(mem_addr),    32'(a[7:0]));
    if (wr && !err) chk("cmd_wdata", 32'(mem_wr_data), 32'(d));
    exp_rd = (!wr && !err) ? ref_mem[a[7:0]] : 8'h00;
    if (wr && !err) ref_mem[a[7:0]] = d;
    penable = 1'b1;
    @(posedge clk); #1;
    chk("resp_pready",  32'(pready),  32'd1);
    chk("resp_prdata",  32'(prdata),  32'(exp_rd));
    chk("resp_pslverr", 32'(pslverr), 32'(err));
    chk("resp_ce",      32'(mem_ce),  32'd0);
    @(posedge clk); #1;
    chk("done_pready",  32'(pready),  32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'h00;
      ref_mem[i] = 8'h00;
    end
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_prdata",  32'(prdata),      32'd0);
    chk("rst_pready",  32'(pready),      32'd0);
    chk("rst_pslverr", 32'(pslverr),     32'd0);
    chk("rst_ce",      32'(mem_ce),      32'd0);
    chk("rst_addr",    32'(mem_addr),    32'd0);
    chk("rst_wdata",   32'(mem_wr_data), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Write then read
    xfer(1'b1, 12'h012, 8'hA5); idle(1);
    xfer(1'b0, 12'h012, 8'h00); idle(1);

    // Back-to-back
    xfer(1'b1, 12'h000, 8'h11);
    xfer(1'b1, 12'h001, 8'h22);
    xfer(1'b0, 12'h000, 8'h00);
    xfer(1'b0, 12'h001, 8'h00); idle(1);

    // Address boundary and above-range address
    xfer(1'b1, 12'h0FF, 8'h5A);
    xfer(1'b0, 12'h0FF, 8'h00);
    xfer(1'b1, 12'h100, 8'h77);
    xfer(1'b0, 12'h000, 8'h00);
    xfer(1'b0, 12'h100, 8'h00); idle(1);

    // Reset in CMD of a read
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h030;
    @(posedge clk); #1;
    chk("mrst_cmd_ce", 32'(mem_ce), 32'd1);
    rst = 1'b1; penable = 1'b1;
    @(posedge clk); #1;
    chk("mrst_ce",     32'(mem_ce),   32'd0);
    chk("mrst_rden",   32'(mem_rden), 32'd0);
    chk("mrst_pready", 32'(pready),   32'd0);
    chk("mrst_addr",   32'(mem_addr), 32'd0);
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    chk("mrst_no_pready", 32'(pready), 32'd0);
    xfer(1'b1, 12'h030, 8'h3C); idle(1);
    xfer(1'b0, 12'h030, 8'h00); idle(1);

    // Abort in CMD of a write: write still commits
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h040; pwdata = 8'h99;
    @(posedge clk); #1;
    chk("abort_cmd_wren", 32'(mem_wren), 32'd1);
    ref_mem[8'h40] = 8'h99;
    psel = 1'b0;
    @(posedge clk); #1;
    chk("abort_pready", 32'(pready), 32'd0);
    @(posedge clk); #1;
    chk("abort_pready2", 32'(pready), 32'd0);
    xfer(1'b0, 12'h040, 8'h00); idle(1);

    // Access phase without setup is ignored
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 12'h050; pwdata = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("nosetup_ce",     32'(mem_ce), 32'd0);
      chk("nosetup_pready", 32'(pready), 32'd0);
    end
    idle(1);
    xfer(1'b0, 12'h050, 8'h00); idle(1);

    // Random traffic on a small address pool plus occasional high addresses
    for (int i = 0; i < 80; i++) begin
      logic [11:0] a;
      if ($urandom_range(0, 7) == 0) a = 12'($urandom_range(256, 4095));
      else                           a = 12'($urandom_range(0, 15));
      xfer(1'($urandom_range(0, 1)), a, 8'($urandom));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(2);

    chk("protocol_violations", 32'(viol), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
